sha_const_fetch: RTL and testbench

- Read-side master for the 32-bit SHA-256 constant EEPROM (13-bit address; active-low CE/OE/WE; H0..H7 at addresses 0-7, K0..K63 at addresses 8-71).
- Converts single-word valid/ready requests from the SHA-256 core into correctly sequenced EEPROM read cycles.
- Returns the 32-bit word on a valid/ready response channel.
- Sits between the hash core's schedule/compression control and the external constant ROM.

---
 rtl/sha_pkg.sv | 38 +++
 rtl/sha_const_addr.sv | 28 ++
 rtl/sha_const_fetch.sv | 192 +++++++++++++++++++
 tb/tb_sha_const_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sha_pkg                                                |
// | Description : Shared constants, kind encoding and FSM state type for |
// |               the SHA-256 constant EEPROM fetch block.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sha_pkg;

  // EEPROM layout of the SHA-256 constant table
  localparam int H_BASE  = 0;
  localparam int K_BASE  = 8;
  localparam int H_COUNT = 8;
  localparam int K_COUNT = 64;

  // Bus and field widths
  localparam int ADDR_W = 13;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 4;

  // Request kind encoding
  localparam logic KIND_H = 1'b0;
  localparam logic KIND_K = 1'b1;

  // Fetch FSM; the two prefetch states are only reachable when the
  // prefetch option is compiled in
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_RESP      = 3'd3,
    ST_PF_SETUP  = 3'd4,
    ST_PF_ACCESS = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sha_const_addr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sha_const_addr                                         |
// | Description : Maps a constant kind/index pair onto its EEPROM word   |
// |               address. H uses index[2:0]; K uses the full index.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sha_const_addr #(
  parameter int H_BASE = sha_pkg::H_BASE,
  parameter int K_BASE = sha_pkg::K_BASE
) (
  input  logic                       kind,
  input  logic [sha_pkg::IDX_W-1:0]  index,
  output logic [sha_pkg::ADDR_W-1:0] addr
);
  import sha_pkg::*;

  // H index bits [5:3] are deliberately dropped so H9 aliases H1
  always_comb begin
    if (kind == KIND_K) begin
      addr = ADDR_W'(K_BASE) + {{(ADDR_W-IDX_W){1'b0}}, index};
    end else begin
      addr = ADDR_W'(H_BASE) + {{(ADDR_W-3){1'b0}}, index[2:0]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha_const_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sha_const_fetch                                        |
// | Description : Read master for the SHA-256 constant EEPROM. Turns     |
// |               single-word valid/ready requests into SETUP/ACCESS     |
// |               read cycles and returns the word on a valid/ready      |
// |               response channel.                                      |
// | Options     : SHA_CONST_PREFETCH_EN - speculative read of the next   |
// |               constant after each response, served from a tagged    |
// |               prefetch register on a hit.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sha_const_fetch #(
  parameter int ACCESS_CYCLES = 2,
  parameter int H_BASE        = sha_pkg::H_BASE,
  parameter int K_BASE        = sha_pkg::K_BASE
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic                       REQ_KIND,
  input  logic [sha_pkg::IDX_W-1:0]  REQ_INDEX,
  output logic                       RSP_VALID,
  input  logic                       RSP_READY,
  output logic [sha_pkg::WORD_W-1:0] RSP_DATA,
  output logic [sha_pkg::ADDR_W-1:0] EE_A,
  output logic                       EE_CE,
  output logic                       EE_OE,
  output logic                       EE_WE,
  input  logic [sha_pkg::WORD_W-1:0] EE_IO
);
  import sha_pkg::*;

  // Counter reload: ACCESS lasts ACCESS_CYCLES cycles, sampling on count 0
  localparam logic [CNT_W-1:0] c_acc_load = CNT_W'(ACCESS_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0]   w_req_addr;
  logic                w_ce_n;

  sha_const_addr #(
    .H_BASE (H_BASE),
    .K_BASE (K_BASE)
  ) u_req_addr (
    .kind  (REQ_KIND),
    .index (REQ_INDEX),
    .addr  (w_req_addr)
  );

`ifdef SHA_CONST_PREFETCH_EN
  logic                kind_q, kind_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    w_next_idx;
  logic [ADDR_W-1:0]   w_pf_addr;
  logic                pf_valid_q, pf_valid_d;
  logic [ADDR_W-1:0]   pf_tag_q, pf_tag_d;
  logic [WORD_W-1:0]   pf_data_q, pf_data_d;

  // Next constant of the same kind: H wraps 7->0, K wraps 63->0
  assign w_next_idx = (kind_q == KIND_H) ? {3'b000, idx_q[2:0] + 3'd1}
                                         : idx_q + 6'd1;

  sha_const_addr #(
    .H_BASE (H_BASE),
    .K_BASE (K_BASE)
  ) u_pf_addr (
    .kind  (kind_q),
    .index (w_next_idx),
    .addr  (w_pf_addr)
  );

  // Prefetch bookkeeping registers; reset invalidates the tag
  always_ff @(posedge CLK) begin
    if (RST) begin
      kind_q     <= KIND_H;
      idx_q      <= '0;
      pf_valid_q <= 1'b0;
      pf_tag_q   <= '0;
      pf_data_q  <= '0;
    end else begin
      kind_q     <= kind_d;
      idx_q      <= idx_d;
      pf_valid_q <= pf_valid_d;
      pf_tag_q   <= pf_tag_d;
      pf_data_q  <= pf_data_d;
    end
  end
`endif

  // Main FSM, wait counter, address and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Next-state logic; EE_A only moves in IDLE/RESP, never while CE is low
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
`ifdef SHA_CONST_PREFETCH_EN
    kind_d     = kind_q;
    idx_d      = idx_q;
    pf_valid_d = pf_valid_q;
    pf_tag_d   = pf_tag_q;
    pf_data_d  = pf_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          addr_d  = w_req_addr;
          state_d = ST_SETUP;
`ifdef SHA_CONST_PREFETCH_EN
          kind_d  = REQ_KIND;
          idx_d   = REQ_INDEX;
          if (pf_valid_q && (pf_tag_q == w_req_addr)) begin
            rsp_data_d = pf_data_q;
            state_d    = ST_RESP;
          end
`endif
        end
      end
      ST_SETUP: begin
        cnt_d   = c_acc_load;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          rsp_data_d = EE_IO;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (RSP_READY) begin
`ifdef SHA_CONST_PREFETCH_EN
          addr_d  = w_pf_addr;
          state_d = ST_PF_SETUP;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef SHA_CONST_PREFETCH_EN
      ST_PF_SETUP: begin
        cnt_d   = c_acc_load;
        state_d = ST_PF_ACCESS;
      end
      ST_PF_ACCESS: begin
        if (cnt_q == '0) begin
          pf_data_d  = EE_IO;
          pf_tag_d   = addr_q;
          pf_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes decode straight from state so CE and OE always move together
  assign w_ce_n    = !((state_q == ST_ACCESS) || (state_q == ST_PF_ACCESS));
  assign EE_CE     = w_ce_n;
  assign EE_OE     = w_ce_n;
  assign EE_WE     = 1'b1;
  assign EE_A      = addr_q;
  assign REQ_READY = (state_q == ST_IDLE);
  assign RSP_VALID = (state_q == ST_RESP);
  assign RSP_DATA  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sha_const_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sha_const_fetch                                     |
// | Description : Directed self-checking bench for sha_const_fetch with  |
// |               a behavioural constant EEPROM. Honours                 |
// |               SHA_CONST_PREFETCH_EN for prefetch-hit expectations.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sha_const_fetch;

`ifdef SHA_CONST_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_KIND;
  logic [5:0]  REQ_INDEX;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic [12:0] EE_A;
  logic        EE_CE;
  logic        EE_OE;
  logic        EE_WE;
  logic [31:0] EE_IO;

  int checks   = 0;
  int failures = 0;
  int bad;

  always #5 CLK = ~CLK;

  sha_const_fetch #(
    .ACCESS_CYCLES (2),
    .H_BASE        (0),
    .K_BASE        (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_KIND  (REQ_KIND),
    .REQ_INDEX (REQ_INDEX),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_DATA  (RSP_DATA),
    .EE_A      (EE_A),
    .EE_CE     (EE_CE),
    .EE_OE     (EE_OE),
    .EE_WE     (EE_WE),
    .EE_IO     (EE_IO)
  );

  // Constant EEPROM contents (H0..H7 at 0-7, K0..K7 at 8-15, K63 at 71)
  function automatic logic [31:0] rom(input logic [12:0] a);
    case (a)
      13'd0:   rom = 32'h6a09e667;
      13'd1:   rom = 32'hbb67ae85;
      13'd2:   rom = 32'h3c6ef372;
      13'd3:   rom = 32'ha54ff53a;
      13'd4:   rom = 32'h510e527f;
      13'd5:   rom = 32'h9b05688c;
      13'd6:   rom = 32'h1f83d9ab;
      13'd7:   rom = 32'h5be0cd19;
      13'd8:   rom = 32'h428a2f98;
      13'd9:   rom = 32'h71374491;
      13'd10:  rom = 32'hb5c0fbcf;
      13'd11:  rom = 32'he9b5dba5;
      13'd12:  rom = 32'h3956c25b;
      13'd13:  rom = 32'h59f111f1;
      13'd14:  rom = 32'h923f82a4;
      13'd15:  rom = 32'hab1c5ed5;
      13'd71:  rom = 32'hc67178f2;
      default: rom = 32'hdead0000 | {19'd0, a};
    endcase
  endfunction

  // The EEPROM only drives data while both CE and OE are low
  always_comb EE_IO = (!EE_CE && !EE_OE) ? rom(EE_A) : 32'hxxxxxxxx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, follow it to RESP, and check the bus cycle it made
  task automatic start_and_wait(input logic k, input logic [5:0] i,
                                input logic [12:0] exp_addr, input logic [31:0] exp_data,
                                input int exp_lat, input int exp_ce);
    int lat;
    int ce_low;
    int addr_bad;
    int pair_bad;
    int we_bad;
    REQ_VALID = 1'b1;
    REQ_KIND  = k;
    REQ_INDEX = i;
    chk("req_ready_idle", REQ_READY, 1'b1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    lat = 1; ce_low = 0; addr_bad = 0; pair_bad = 0; we_bad = 0;
    while (!RSP_VALID && lat < 40) begin
      if (!EE_CE) begin
        ce_low++;
        if (EE_A !== exp_addr) addr_bad++;
      end
      if (EE_CE !== EE_OE) pair_bad++;
      if (EE_WE !== 1'b1) we_bad++;
      @(posedge CLK); #1;
      lat++;
    end
    chk("rsp_latency", lat, exp_lat);
    chk("ce_low_cycles", ce_low, exp_ce);
    chk("addr_during_access", addr_bad, 0);
    chk("ce_oe_together", pair_bad, 0);
    chk("we_high", we_bad, 0);
    chk("ce_high_in_resp", EE_CE, 1'b1);
    chk("rsp_data", RSP_DATA, exp_data);
  endtask

  // Hold the response for 'hold' cycles, then complete the handshake
  task automatic finish_rsp(input int hold, input logic [31:0] exp_data);
    int stall_bad;
    stall_bad = 0;
    for (int c = 0; c < hold; c++) begin
      @(posedge CLK); #1;
      if (RSP_VALID !== 1'b1 || RSP_DATA !== exp_data || REQ_READY !== 1'b0 || EE_CE !== 1'b1)
        stall_bad++;
    end
    if (hold > 0) chk("backpressure_stable", stall_bad, 0);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    chk("rsp_valid_cleared", RSP_VALID, 1'b0);
    chk("rsp_data_kept", RSP_DATA, exp_data);
`ifdef SHA_CONST_PREFETCH_EN
    for (int c = 0; c < 30 && !REQ_READY; c++) begin
      @(posedge CLK); #1;
    end
    chk("prefetch_done", REQ_READY, 1'b1);
`else
    chk("req_ready_after_hs", REQ_READY, 1'b1);
`endif
  endtask

  initial begin
    RST       = 1'b1;
    REQ_VALID = 1'b0;
    REQ_KIND  = 1'b0;
    REQ_INDEX = 6'd0;
    RSP_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ce", EE_CE, 1'b1);
    chk("rst_oe", EE_OE, 1'b1);
    chk("rst_we", EE_WE, 1'b1);
    chk("rst_addr", EE_A, 13'd0);
    chk("rst_req_ready", REQ_READY, 1'b1);
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_rsp_data", RSP_DATA, 32'h0);
    RST = 1'b0;

    // Plain reads across both kinds and the table edges
    start_and_wait(1'b0, 6'd0,  13'd0,  32'h6a09e667, 4, 2); finish_rsp(0, 32'h6a09e667);
    start_and_wait(1'b1, 6'd0,  13'd8,  32'h428a2f98, 4, 2); finish_rsp(0, 32'h428a2f98);
    start_and_wait(1'b1, 6'd63, 13'd71, 32'hc67178f2, 4, 2); finish_rsp(0, 32'hc67178f2);
    start_and_wait(1'b0, 6'd15, 13'd7,  32'h5be0cd19, 4, 2); finish_rsp(0, 32'h5be0cd19);
    start_and_wait(1'b0, 6'd9,  13'd1,  32'hbb67ae85, 4, 2); finish_rsp(0, 32'hbb67ae85);

    // Back-pressure with a second request held during the stall
    start_and_wait(1'b1, 6'd2, 13'd10, 32'hb5c0fbcf, 4, 2);
    REQ_VALID = 1'b1;
    REQ_KIND  = 1'b1;
    REQ_INDEX = 6'd3;
    finish_rsp(10, 32'hb5c0fbcf);
    start_and_wait(1'b1, 6'd3, 13'd11, 32'he9b5dba5, PF ? 1 : 4, PF ? 0 : 2);
    finish_rsp(0, 32'he9b5dba5);

    // Reset in the middle of ACCESS for K5
    REQ_VALID = 1'b1;
    REQ_KIND  = 1'b1;
    REQ_INDEX = 6'd5;
    chk("req_ready_before_k5", REQ_READY, 1'b1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("k5_in_access", EE_CE, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("mid_rst_ce", EE_CE, 1'b1);
    chk("mid_rst_oe", EE_OE, 1'b1);
    chk("mid_rst_rsp_valid", RSP_VALID, 1'b0);
    chk("mid_rst_req_ready", REQ_READY, 1'b1);
    chk("mid_rst_addr", EE_A, 13'd0);
    chk("mid_rst_rsp_data", RSP_DATA, 32'h0);
    bad = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (RSP_VALID !== 1'b0 || EE_CE !== 1'b1) bad++;
    end
    chk("no_partial_rsp", bad, 0);
    start_and_wait(1'b1, 6'd5, 13'd13, 32'h59f111f1, 4, 2); finish_rsp(0, 32'h59f111f1);

    // K0 then K1 from a clean reset: K1 is a prefetch hit when enabled
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    start_and_wait(1'b1, 6'd0, 13'd8, 32'h428a2f98, 4, 2);           finish_rsp(0, 32'h428a2f98);
    start_and_wait(1'b1, 6'd1, 13'd9, 32'h71374491, PF ? 1 : 4, PF ? 0 : 2); finish_rsp(0, 32'h71374491);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
